debounce: RTL
=============

# debounce

Input conditioner for asynchronous, bouncy external signals such as buttons, jumpers and slow handshake lines from off-board logic. It synchronizes the raw input into the `clock` domain. It then accepts a level change only after the synchronized input has held the new level for `CYCLES` consecutive cycles. It reports the accepted level plus single-cycle `rise`/`fall` event pulses. It is the receiving counterpart of `oneshot`: `oneshot` stretches an internal event into a long level, while this block collapses an external long or noisy level back into clean internal events.

## Interface
- `CYCLES`, default 64: consecutive stable cycles required to accept a level change. Legal range is ≥ 2.
- `SYNC_STAGES`, default 2: length of the input synchronizer chain. Legal range is ≥ 2.
- `clock`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in`  input  1  raw asynchronous input; no timing relation to `clock`.
- `out`  output  1  debounced level; registered.
- `rise`  output  1  one-cycle pulse when `out` goes 0→1; registered.
- `fall`  output  1  one-cycle pulse when `out` goes 1→0; registered.

## Operation
- **Synchronizer:** a chain of `SYNC_STAGES` flops. `in` enters stage 0. Call the last stage `s`. All stages are 0 while in reset.
- **Counter:** width `$clog2(CYCLES)`. It saturates by construction and never wraps.
- **FSM states:** LOW, RISING, HIGH, FALLING. Reset state is LOW with counter = 0.
- **LOW**
  - `s`=1: go to RISING, counter ← 1.
  - `s`=0: stay in LOW.
- **RISING**
  - `s`=0: glitch. Return to LOW, counter ← 0, no pulse.
  - `s`=1 and counter == `CYCLES`-1: go to HIGH, counter ← 0, `out` ← 1, `rise` ← 1.
  - Otherwise: counter ← counter+1.
- **HIGH**
  - `s`=0: go to FALLING, counter ← 1.
  - `s`=1: stay in HIGH.
- **FALLING**
  - `s`=1: glitch. Return to HIGH, counter ← 0, no pulse.
  - `s`=0 and counter == `CYCLES`-1: go to LOW, counter ← 0, `out` ← 0, `fall` ← 1.
  - Otherwise: counter ← counter+1.
- **Output rules:**
  - `out` is 1 exactly in HIGH and FALLING.
  - `rise` and `fall` are each high for exactly one cycle per accepted transition.
  - `rise` and `fall` are never high together.
  - Pulses of the same kind never occur on consecutive cycles.
- **Restart on any bounce:** a bounce restarts the stability window. No partial credit is kept across a glitch, so `CYCLES`-1 highs, one low, then `CYCLES`-1 highs produces no transition.

## Timing
- **Reset values:** `out`=0, `rise`=0, `fall`=0, all synchronizer stages 0, state LOW. Values apply immediately on `reset` assertion, independent of `clock`.
- **Latency:** number clock edges from 1 at the first edge that samples the new `in` level.
  - `s` takes the new level after edge `SYNC_STAGES`.
  - `out` and the event pulse change after edge `SYNC_STAGES`+`CYCLES`.
  - With defaults this is edge 66.
- **Asynchronous input:** the first-sample edge of `in` is uncertain by ±1 cycle. Only the count of stable samples at `s` is exact.
- **Pulse width rule:** a clean input pulse of width W produces:
  - for W ≥ `CYCLES`: an `out` pulse of width W, delayed by `SYNC_STAGES`+`CYCLES`;
  - for W < `CYCLES`: no output.
- **Reset mid-window:** the partial count is discarded and the pulses are cleared. After release, the block re-qualifies from LOW. If `in` is held at 1, `out` rises `SYNC_STAGES`+`CYCLES` edges after release.
- **Steady state:** no combinational path from `in` to any output. Outputs are glitch-free.

## Test plan
- **Reset and clean rise:** hold `reset` for 3 cycles. Release with `in`=0 → all outputs 0. Raise `in` and hold → `out`=1 and `rise`=1 after exactly edge 66, with `rise` low again at edge 67. `fall` stays 0 throughout.
- **Short glitches rejected:** drive `in` high for 63 cycles, low for 1, high for 63, then low for 200 → `out`, `rise` and `fall` stay 0 throughout.
- **Threshold pulse:** drive `in` high for exactly 64 cycles, then low → `out` high for exactly 64 cycles starting at edge 66. Exactly one `rise` and one `fall` occur, 64 cycles apart.
- **Bounce on falling edge:** with `out`=1, drive `in` low for 30 cycles, high for 2, then low and hold → `out` stays 1. `fall` occurs 64 cycles after the final low reaches `s`. No `rise` occurs.
- **Async reset mid-window:**
  - with `in`=1, assert `reset` 40 cycles into RISING → `out`=0 immediately and no pulse;
  - release with `in` still 1 → `rise` occurs 66 edges after release.
- **Parameter sweep:** repeat the clean-rise test with `CYCLES`=2, `SYNC_STAGES`=3 → `out` rises at edge 5. Toggle `in` every cycle for 100 cycles → no output change.

Source files
------------

// File: rtl/debounce.sv
// Debouncer for asynchronous, bouncy inputs: synchronizer chain followed by a
// stability-window FSM that emits a clean level plus one-cycle rise/fall events.
module debounce #(
  parameter int CYCLES      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;

  // The window closes at LAST, so the count can never step past it.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LAST) ? LAST : v + CW'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p0;

  state_t                 state_p1, state_n;
  logic [CW-1:0]          cnt_p1, cnt_n;
  logic                   out_n, rise_n, fall_n;

  // Stage p0: metastability-hardening chain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in};
    end
  end

  assign s_p0 = sync_p0[SYNC_STAGES-1];

  always_comb begin
    state_n = state_p1;
    cnt_n   = cnt_p1;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state_p1)
      LOW: begin
        if (s_p0) begin
          state_n = RISING;
          cnt_n   = CW'(1);
        end
      end
      RISING: begin
        if (!s_p0) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt_p1 == LAST) begin
          state_n = HIGH;
          cnt_n   = '0;
          rise_n  = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_p1);
        end
      end
      HIGH: begin
        if (!s_p0) begin
          state_n = FALLING;
          cnt_n   = CW'(1);
        end
      end
      FALLING: begin
        if (s_p0) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt_p1 == LAST) begin
          state_n = LOW;
          cnt_n   = '0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_p1);
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase
    out_n = (state_n == HIGH) || (state_n == FALLING);
  end

  // Stage p1: qualification state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p1 <= LOW;
      cnt_p1   <= '0;
      out      <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      state_p1 <= state_n;
      cnt_p1   <= cnt_n;
      out      <= out_n;
      rise     <= rise_n;
      fall     <= fall_n;
    end
  end

endmodule
